// File: rtl/common_types_pkg.sv
// ============================================================================
//  Module      : common_types_pkg
//  Description : Shared types for the MEM stage: FSM states and access sizes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package common_types_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } memstg_state_t;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/memory_stage_ctrl_if.sv
// ============================================================================
//  Module      : memory_stage_ctrl_if
//  Description : Data-memory bus between the MEM stage and the memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface memory_stage_ctrl_if;
   logic        dreq_ren;
   logic        dreq_wen;
   logic [31:0] dreq_addr;
   logic [31:0] dreq_wdata;
   logic [3:0]  dreq_strobe;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dreq_ren, dreq_wen, dreq_addr, dreq_wdata, dreq_strobe,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dreq_ren, dreq_wen, dreq_addr, dreq_wdata, dreq_strobe,
      output dmem_ready, dmem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module      : mem_lane_align
//  Description : Byte-lane strobes, store replication, load right-justify and
//                misalignment detection (purely combinational).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
   import common_types_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  strobe,
   output logic [31:0] wdata_lanes,
   output logic [31:0] load_data,
   output logic        misaligned
);

   always_comb begin
      strobe      = 4'b1111;
      wdata_lanes = wdata;
      misaligned  = 1'b0;
      case (size)
         MEM_BYTE: begin
            strobe      = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
         end
         MEM_HALF: begin
            strobe      = 4'b0011 << addr_lo;
            wdata_lanes = {2{wdata[15:0]}};
            misaligned  = addr_lo[0];
         end
         // Word and the unused encoding both behave as a full word
         default: begin
            strobe      = 4'b1111;
            wdata_lanes = wdata;
            misaligned  = (addr_lo != 2'b00);
         end
      endcase
   end

   assign load_data = rdata >> {addr_lo, 3'b000};

endmodule

`default_nettype wire

// File: rtl/memory_stage_ctrl.sv
// ============================================================================
//  Module      : memory_stage_ctrl
//  Description : MEM-stage sequencer: issues loads/stores to the data bus,
//                absorbs wait states, and steers the mem/wb latch and stall.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_stage_ctrl
   import common_types_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_valid,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [1:0]          mem_size,
   input  logic [31:0]         mem_addr,
   input  logic [31:0]         mem_wdata,
   input  logic                ext_flush,
   memory_stage_ctrl_if.master dbus,
   output logic [31:0]         dload,
   output logic                mem_wb_en,
   output logic                mem_wb_flush,
   output logic                stall,
   output logic                fault
);

   localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   memstg_state_t    r_state;
   memstg_state_t    w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             r_flush_seen;
   logic [31:0]      r_dload;

   logic        w_access;
   logic        w_timeout;
   logic [3:0]  w_strobe;
   logic [31:0] w_wdata_lanes;
   logic [31:0] w_load_data;
   logic        w_misaligned;

   logic        w_ren;
   logic        w_wen;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [3:0]  w_strobe_out;

   mem_lane_align u_align (
      .size        (mem_size),
      .addr_lo     (mem_addr[1:0]),
      .wdata       (mem_wdata),
      .rdata       (dbus.dmem_rdata),
      .strobe      (w_strobe),
      .wdata_lanes (w_wdata_lanes),
      .load_data   (w_load_data),
      .misaligned  (w_misaligned)
   );

   assign w_access = mem_valid & (mem_read | mem_write);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_err        <= 1'b0;
         r_flush_seen <= 1'b0;
         r_dload      <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ACCESS: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (dbus.dmem_ready) r_dload <= w_load_data;
               if (w_timeout) r_err <= 1'b1;
               // A flush never aborts the bus cycle; it is replayed in DONE
               if (ext_flush) r_flush_seen <= 1'b1;
            end
            DONE: begin
               r_cnt        <= '0;
               r_err        <= 1'b0;
               r_flush_seen <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_timeout    = 1'b0;
      w_ren        = 1'b0;
      w_wen        = 1'b0;
      w_addr       = '0;
      w_wdata      = '0;
      w_strobe_out = '0;
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b0;
      stall        = 1'b0;
      fault        = 1'b0;
      if (rst) begin
         mem_wb_flush = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               mem_wb_flush = ext_flush;
               if (w_access) begin
                  if (w_misaligned) begin
                     fault        = 1'b1;
                     mem_wb_flush = 1'b1;
                  end else begin
                     stall        = 1'b1;
                     mem_wb_en    = 1'b0;
                     w_next_state = ACCESS;
                  end
               end
            end
            ACCESS: begin
               // A read+write combination is issued as a plain store
               w_ren        = mem_read & ~mem_write;
               w_wen        = mem_write;
               w_addr       = {mem_addr[31:2], 2'b00};
               w_wdata      = w_wdata_lanes;
               w_strobe_out = mem_write ? w_strobe : 4'b0000;
               stall        = 1'b1;
               mem_wb_en    = 1'b0;
               if (dbus.dmem_ready) begin
                  w_next_state = DONE;
               end else if (r_cnt == CNT_LAST) begin
                  w_timeout    = 1'b1;
                  w_next_state = DONE;
               end
            end
            DONE: begin
               mem_wb_flush = r_err | r_flush_seen;
               fault        = r_err;
               w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   assign dbus.dreq_ren    = w_ren;
   assign dbus.dreq_wen    = w_wen;
   assign dbus.dreq_addr   = w_addr;
   assign dbus.dreq_wdata  = w_wdata;
   assign dbus.dreq_strobe = w_strobe_out;
   assign dload            = r_dload;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage_ctrl.sv
// ============================================================================
//  Module      : tb_memory_stage_ctrl
//  Description : Self-checking bench for memory_stage_ctrl with a result queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_stage_ctrl;

   localparam int TMO = 4;

   typedef struct {
      logic [31:0] dload;
      logic        flush;
      logic        fault;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        ext_flush;
   logic [31:0] dload;
   logic        mem_wb_en;
   logic        mem_wb_flush;
   logic        stall;
   logic        fault;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_dload = '0;
   exp_t        sb_q[$];

   memory_stage_ctrl_if bus ();

   memory_stage_ctrl #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_valid    (mem_valid),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .ext_flush    (ext_flush),
      .dbus         (bus.master),
      .dload        (dload),
      .mem_wb_en    (mem_wb_en),
      .mem_wb_flush (mem_wb_flush),
      .stall        (stall),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_load(input logic [31:0] r, input logic [1:0] a);
      case (a)
         2'd0:    return r;
         2'd1:    return {8'h00, r[31:8]};
         2'd2:    return {16'h0000, r[31:16]};
         default: return {24'h000000, r[31:24]};
      endcase
   endfunction

   function automatic logic [3:0] exp_strobe(input logic [1:0] sz, input logic [1:0] a);
      if (sz == 2'd0) begin
         case (a)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
         endcase
      end else if (sz == 2'd1) begin
         return a[1] ? 4'b1100 : 4'b0011;
      end
      return 4'b1111;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
      if (sz == 2'd1) return {w[15:0], w[15:0]};
      return w;
   endfunction

   // Runs one aligned access; memory answers after 'waits' ACCESS cycles
   task automatic run_access(input string name, input logic rd, input logic wr,
                             input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int waits, input int flush_at,
                             output int stall_cycles);
      exp_t e;
      logic timed_out;
      int   last_acc;
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = size;
      mem_addr = addr; mem_wdata = wdata; ext_flush = 1'b0;
      bus.dmem_ready = 1'b0; bus.dmem_rdata = rdata;
      timed_out = (waits >= TMO);
      last_acc  = timed_out ? TMO - 1 : waits;
      e.dload   = timed_out ? model_dload : exp_load(rdata, addr[1:0]);
      e.flush   = timed_out || (flush_at >= 0 && flush_at <= last_acc);
      e.fault   = timed_out;
      model_dload = e.dload;
      sb_q.push_back(e);
      stall_cycles = 0;
      @(negedge clk);
      if (stall === 1'b1) stall_cycles++;
      n_checks++;
      if (stall !== 1'b1 || mem_wb_en !== 1'b0 || bus.dreq_ren !== 1'b0 || bus.dreq_wen !== 1'b0) begin
         n_errors++;
         $display("FAIL %s issue: stall=%b en=%b ren=%b wen=%b required 1 0 0 0",
                  name, stall, mem_wb_en, bus.dreq_ren, bus.dreq_wen);
      end
      for (int i = 0; i < TMO; i++) begin
         @(posedge clk); #1;
         bus.dmem_ready = (i == waits);
         ext_flush      = (i == flush_at);
         @(negedge clk);
         if (stall === 1'b1) stall_cycles++;
         n_checks++;
         if (bus.dreq_ren !== (rd & ~wr) || bus.dreq_wen !== wr ||
             bus.dreq_addr !== {addr[31:2], 2'b00} || stall !== 1'b1 || mem_wb_en !== 1'b0) begin
            n_errors++;
            $display("FAIL %s access%0d: ren=%b wen=%b addr=%h stall=%b en=%b required %b %b %h 1 0",
                     name, i, bus.dreq_ren, bus.dreq_wen, bus.dreq_addr, stall, mem_wb_en,
                     rd & ~wr, wr, {addr[31:2], 2'b00});
         end
         if (wr) begin
            n_checks++;
            if (bus.dreq_strobe !== exp_strobe(size, addr[1:0]) ||
                bus.dreq_wdata !== exp_wdata(size, wdata)) begin
               n_errors++;
               $display("FAIL %s lanes%0d: strobe=%b wdata=%h required %b %h", name, i,
                        bus.dreq_strobe, bus.dreq_wdata, exp_strobe(size, addr[1:0]),
                        exp_wdata(size, wdata));
            end
         end
         if (i == waits) break;
      end
      @(posedge clk); #1;
      bus.dmem_ready = 1'b0; ext_flush = 1'b0;
      mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      if (stall === 1'b1) stall_cycles++;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s done: result queue empty, required one entry", name);
      end else begin
         e = sb_q.pop_front();
         if (dload !== e.dload || mem_wb_flush !== e.flush || fault !== e.fault ||
             stall !== 1'b0 || mem_wb_en !== 1'b1 || bus.dreq_ren !== 1'b0 || bus.dreq_wen !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done: dload=%h flush=%b fault=%b stall=%b en=%b ren=%b wen=%b required %h %b %b 0 1 0 0",
                     name, dload, mem_wb_flush, fault, stall, mem_wb_en, bus.dreq_ren,
                     bus.dreq_wen, e.dload, e.flush, e.fault);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.dreq_ren !== 1'b0 || bus.dreq_wen !== 1'b0 || dload !== 32'h0 || stall !== 1'b0 ||
          fault !== 1'b0 || mem_wb_en !== 1'b1 || mem_wb_flush !== 1'b1) begin
         n_errors++;
         $display("FAIL reset: ren=%b wen=%b dload=%h stall=%b fault=%b en=%b flush=%b required 0 0 0 0 0 1 1",
                  bus.dreq_ren, bus.dreq_wen, dload, stall, fault, mem_wb_en, mem_wb_flush);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_wb_flush !== 1'b0 || mem_wb_en !== 1'b1 || stall !== 1'b0) begin
         n_errors++;
         $display("FAIL post_reset: flush=%b en=%b stall=%b required 0 1 0",
                  mem_wb_flush, mem_wb_en, stall);
      end
   endtask

   task automatic test_alu_op();
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_wb_en !== 1'b1 || stall !== 1'b0 || bus.dreq_ren !== 1'b0 || bus.dreq_wen !== 1'b0 ||
             mem_wb_flush !== 1'b0 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_op%0d: en=%b stall=%b ren=%b wen=%b flush=%b fault=%b required 1 0 0 0 0 0",
                     i, mem_wb_en, stall, bus.dreq_ren, bus.dreq_wen, mem_wb_flush, fault);
         end
         @(posedge clk); #1;
      end
      ext_flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mem_wb_flush !== 1'b1 || dload !== model_dload) begin
         n_errors++;
         $display("FAIL idle_flush: flush=%b dload=%h required 1 %h", mem_wb_flush, dload, model_dload);
      end
      @(posedge clk); #1;
      ext_flush = 1'b0; mem_valid = 1'b0; bus.dmem_ready = 1'b0;
   endtask

   task automatic test_misaligned(input string name, input logic [1:0] size, input logic [31:0] addr);
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = size; mem_addr = addr;
      @(negedge clk);
      n_checks++;
      if (fault !== 1'b1 || mem_wb_flush !== 1'b1 || mem_wb_en !== 1'b1 || stall !== 1'b0 ||
          bus.dreq_ren !== 1'b0) begin
         n_errors++;
         $display("FAIL %s: fault=%b flush=%b en=%b stall=%b ren=%b required 1 1 1 0 0",
                  name, fault, mem_wb_flush, mem_wb_en, stall, bus.dreq_ren);
      end
      @(posedge clk); #1;
      mem_valid = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fault !== 1'b0 || stall !== 1'b0 || bus.dreq_ren !== 1'b0) begin
         n_errors++;
         $display("FAIL %s after: fault=%b stall=%b ren=%b required 0 0 0",
                  name, fault, stall, bus.dreq_ren);
      end
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_0300;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (bus.dreq_ren !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid pre: ren=%b required 1", bus.dreq_ren);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.dreq_ren !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid drop: ren=%b required 0", bus.dreq_ren);
      end
      rst = 1'b0; mem_valid = 1'b0; mem_read = 1'b0;
      model_dload = 32'h0;
      @(negedge clk);
      n_checks++;
      if (bus.dreq_ren !== 1'b0 || stall !== 1'b0 || dload !== model_dload) begin
         n_errors++;
         $display("FAIL rst_mid idle: ren=%b stall=%b dload=%h required 0 0 %h",
                  bus.dreq_ren, stall, dload, model_dload);
      end
   endtask

   task automatic check_stall(input string name, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s stall_cycles: got %0d required %0d", name, got, want);
      end
   endtask

   initial begin
      int sc;
      rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
      mem_addr = '0; mem_wdata = '0; ext_flush = 1'b0;
      bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;

      test_reset();
      test_alu_op();

      run_access("lw_fast", 1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, -1, sc);
      check_stall("lw_fast", sc, 2);

      run_access("sb_wait", 1'b0, 1'b1, 2'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 3, -1, sc);
      check_stall("sb_wait", sc, 5);

      run_access("sh_rw", 1'b1, 1'b1, 2'd1, 32'h0000_0042, 32'h1234_BEEF, 32'h5566_7788, 1, -1, sc);

      test_misaligned("lh_mis", 2'd1, 32'h0000_0101);
      test_misaligned("lw_mis", 2'd2, 32'h0000_0102);

      run_access("lw_timeout", 1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 99, -1, sc);
      check_stall("lw_timeout", sc, TMO + 1);

      run_access("lbu_flush", 1'b1, 1'b0, 2'd0, 32'h0000_0202, 32'h0, 32'h1122_3344, 1, 0, sc);

      // Back-to-back: a store issued the cycle after a load's result
      run_access("b2b_lh", 1'b1, 1'b0, 2'd1, 32'h0000_0502, 32'h0, 32'hA1B2_C3D4, 2, -1, sc);
      run_access("b2b_sw", 1'b0, 1'b1, 2'd2, 32'h0000_0504, 32'h0BAD_CAFE, 32'h0000_0001, 0, -1, sc);

      test_reset_mid_access();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
